// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: input synchronizers, button debouncers, count prescalers and
// the run/pause/adjust state machine. Every output is registered on clk.
module stopwatch_ctrl #(
  parameter int DIV_1HZ   = 100_000_000,
  parameter int DIV_2HZ   = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       cnt_en,
  output logic [1:0] cnt_mode,
  output logic       cnt_clr,
  output logic       blink,
  output logic [1:0] state
);

  localparam int P1_W = (DIV_1HZ > 1) ? $clog2(DIV_1HZ) : 1;
  localparam int P2_W = (DIV_2HZ > 1) ? $clog2(DIV_2HZ) : 1;
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [P1_W-1:0] P1_LAST = P1_W'(DIV_1HZ - 1);
  localparam logic [P2_W-1:0] P2_LAST = P2_W'(DIV_2HZ - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_ADJ    = 2'b10
  } state_t;

  // bit order: [0] pause, [1] clear, [2] adjust, [3] select
  logic [3:0] raw;
  logic [3:0] sync1_reg, sync2_reg;
  logic [1:0] press;

  assign raw = {sw_sel, sw_adj, btn_clr, btn_pause};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      logic [DB_W-1:0] cnt_reg;
      logic            level_reg, level_d_reg, press_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
          press_reg   <= 1'b0;
        end else begin
          if (sync2_reg[gi] == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            cnt_reg   <= '0;
            level_reg <= sync2_reg[gi];
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
          level_d_reg <= level_reg;
          press_reg   <= level_reg & ~level_d_reg;
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic press_pause, press_clr, adj_s, sel_s;
  assign press_pause = press[0];
  assign press_clr   = press[1];
  assign adj_s       = sync2_reg[2];
  assign sel_s       = sync2_reg[3];

  logic [P1_W-1:0] p1_reg;
  logic [P2_W-1:0] p2_reg;
  logic            tick1, tick2;
  state_t          state_reg, state_next;

  assign tick1 = (p1_reg == P1_LAST);
  assign tick2 = (p2_reg == P2_LAST);

  // The 1 Hz phase is frozen outside RUN so a resumed second keeps its fraction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_reg <= '0;
      p2_reg <= '0;
    end else begin
      if (press_clr) begin
        p1_reg <= '0;
      end else if (state_reg == ST_RUN) begin
        p1_reg <= tick1 ? '0 : p1_reg + P1_W'(1);
      end
      if (press_clr || state_reg != ST_ADJ) begin
        p2_reg <= '0;
      end else begin
        p2_reg <= tick2 ? '0 : p2_reg + P2_W'(1);
      end
    end
  end

  logic       cnt_en_reg, cnt_en_next;
  logic [1:0] cnt_mode_reg, cnt_mode_next;
  logic       cnt_clr_reg;
  logic       blink_reg, blink_next;

  always_comb begin
    state_next    = state_reg;
    cnt_en_next   = 1'b0;
    cnt_mode_next = 2'b00;
    blink_next    = 1'b0;
    unique case (state_reg)
      ST_RUN: begin
        cnt_en_next = tick1;
        if (adj_s) state_next = ST_ADJ;
        else if (press_pause) state_next = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (adj_s) state_next = ST_ADJ;
        else if (press_pause) state_next = ST_RUN;
      end
      ST_ADJ: begin
        cnt_en_next   = tick2;
        cnt_mode_next = sel_s ? 2'b10 : 2'b01;
        blink_next    = blink_reg ^ tick2;
        if (!adj_s) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    // a clear owns its output cycle so the counter never sees clear and increment together
    if (press_clr) cnt_en_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      cnt_en_reg   <= 1'b0;
      cnt_mode_reg <= 2'b00;
      cnt_clr_reg  <= 1'b0;
      blink_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_en_reg   <= cnt_en_next;
      cnt_mode_reg <= cnt_mode_next;
      cnt_clr_reg  <= press_clr;
      blink_reg    <= blink_next;
    end
  end

  assign cnt_en   = cnt_en_reg;
  assign cnt_mode = cnt_mode_reg;
  assign cnt_clr  = cnt_clr_reg;
  assign blink    = blink_reg;
  assign state    = state_reg;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and scheduling unit for the stopwatch counter. It generates the count enables from the 100 MHz board clock and debounces the pause and clear buttons. It also synchronizes the adjust and select switches and runs the run/pause/adjust state machine. The minutes/seconds counter is then a plain enable-driven datapath on `clk`, with no derived clocks, and the display driver takes `blink` and `state` from this block.

## Interface
Parameters:
- `DIV_1HZ`, default 100_000_000, is the number of `clk` cycles per normal count tick.
- `DIV_2HZ`, default 50_000_000, is the number of `clk` cycles per adjust-mode tick.
- `DB_CYCLES`, default 1_000_000, is the number of consecutive stable cycles required to accept a button change (10 ms).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_pause`  in  1  raw pause button, active-high, asynchronous to `clk`.
- `btn_clr`  in  1  raw clear button, active-high, asynchronous.
- `sw_adj`  in  1  raw adjust switch; 1 selects adjust mode.
- `sw_sel`  in  1  raw select switch; 1 selects seconds, 0 selects minutes.
- `cnt_en`  out  1  single-cycle increment enable to the counter.
- `cnt_mode`  out  2  increment mode: 00 normal carry chain, 01 increment minutes only, 10 increment seconds only.
- `cnt_clr`  out  1  single-cycle synchronous clear to the counter.
- `blink`  out  1  blink phase for the digits being adjusted.
- `state`  out  2  FSM state: 00 RUN, 01 PAUSED, 10 ADJ.

## Operation
- **Synchronizers:** each raw input passes through a 2-flop synchronizer, reset to 0.
- **Button debounce, per button:**
  - A counter runs while the synchronized input differs from the debounced level, and resets to 0 when they are equal.
  - When the input has differed for `DB_CYCLES` consecutive cycles, the level takes the input value and the counter resets.
  - A debounced 0->1 transition produces a one-cycle press pulse.
  - Switches are synchronized only, not debounced.
- **Prescalers:**
  - The 1 Hz counter runs 0..`DIV_1HZ`-1 and raises `tick1` in its terminal cycle, then wraps to 0.
  - The 2 Hz counter works the same way with `DIV_2HZ`, raising `tick2`.
  - The 1 Hz counter holds its value in PAUSED and ADJ, so a resumed second continues from its fractional count.
  - The 2 Hz counter runs only in ADJ and is held at 0 elsewhere.
  - A clear press resets both counters to 0.
- **FSM states:** RUN (reset state), PAUSED, ADJ.
- **FSM transitions:**
  - RUN to PAUSED on a pause press.
  - PAUSED to RUN on a pause press.
  - RUN or PAUSED to ADJ when the synchronized `sw_adj` is 1. This has priority over a same-cycle pause press, and the paused condition is discarded.
  - ADJ to RUN when the synchronized `sw_adj` is 0.
  - Pause presses in ADJ are ignored.
- **Outputs, all registered:**
  - `cnt_en` = `tick1` in RUN, `tick2` in ADJ, 0 in PAUSED.
  - `cnt_mode` = 00 in RUN and PAUSED. In ADJ it is 10 if the synchronized `sw_sel` is 1, else 01. `sw_sel` is sampled every cycle, so a change takes effect on the next enable.
  - `cnt_clr` pulses for one cycle on a clear press in any state. The state is unchanged, and `cnt_en` is forced to 0 in the same output cycle.
  - `blink` is cleared to 0 on entry to ADJ and toggles on each `tick2` while in ADJ, giving a 1 Hz square wave. It is 0 outside ADJ.
- **Reset values:** `cnt_en`=0, `cnt_mode`=00, `cnt_clr`=0, `blink`=0, `state`=00. All counters, synchronizers and debounced levels are 0.
- **Reset mid-operation:** state, prescalers and any partial debounce count are discarded immediately.

## Timing
- Button latency, from a raw edge that stays stable to the `cnt_clr` pulse or the `state` change: 2 synchronizer cycles + `DB_CYCLES` + 1 (press pulse) + 1 (output register).
- Switch latency: 2 synchronizer cycles + 1 cycle to `state` or `cnt_mode`.
- `cnt_en` appears one cycle after the terminal prescaler cycle and is exactly one cycle wide.
- RUN enable spacing is exactly `DIV_1HZ` cycles; ADJ enable spacing is exactly `DIV_2HZ` cycles.
- After `rst` deasserts, the first RUN `cnt_en` is high in cycle `DIV_1HZ`+1, counting the first rising edge after deassertion as cycle 1.
- `cnt_en` and `cnt_clr` are never high in the same cycle.
- Throughput: one enable per tick, with no backpressure from the counter.

## Test plan
All scenarios use `DIV_1HZ`=10, `DIV_2HZ`=5, `DB_CYCLES`=4.
1. Reset release, hold all inputs low for 50 cycles -> `cnt_en` pulses at cycles 11, 21, 31, 41; `cnt_mode`=00 and `state`=00 throughout.
2. `btn_pause` bounces 1-0-1 within 3 cycles, then held high for 10 cycles -> exactly one transition to PAUSED and no `cnt_en` while paused. A second clean press returns RUN, and the next `cnt_en` comes after the held remainder of the prescaler count.
3. `sw_adj`=1, `sw_sel`=0 -> `state`=10, `cnt_mode`=01, `cnt_en` every 5 cycles, `blink` toggling every 5 cycles starting from 0. Then `sw_sel`=1 -> `cnt_mode`=10 from the next enable onward.
4. Clear press while in RUN with the prescaler at count 7 -> one `cnt_clr` pulse, `state` stays RUN, and the next `cnt_en` arrives exactly 10 cycles after the clear.
5. In PAUSED, `sw_adj` rises in the same cycle as a pause press -> `state`=10. When `sw_adj` returns to 0 -> `state`=00 (RUN, not PAUSED).
6. Assert `rst` mid-debounce and mid-ADJ -> all outputs return to reset values immediately; no press pulse is produced after release.
